// File: rtl/if_fetch_stage.sv
// Pre-IF + IF fetch stage: issues nextpc to a 1-cycle-latency inst SRAM and hands {pc, inst} to decode.
// Optional macro IF_ADEF_EN adds misaligned-fetch detection (no SRAM request, inst forced to 0).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_excp_adef
);

  logic        fs_valid_reg;
  logic [31:0] fs_pc_reg;
  logic        buf_valid_reg;
  logic [31:0] inst_buf_reg;
  logic        br_pending_reg;
  logic [31:0] br_pend_target_reg;

  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fetch_ok;
  logic        pc_misaligned;

  assign fs_allowin = ~fs_valid_reg | ds_allowin;
  assign seq_pc     = fs_pc_reg + 32'd4;
  assign nextpc     = br_taken       ? br_target          :
                      br_pending_reg ? br_pend_target_reg : seq_pc;

`ifdef IF_ADEF_EN
  assign fetch_ok      = (nextpc[1:0] == 2'b00);
  assign pc_misaligned = (fs_pc_reg[1:0] != 2'b00);
`else
  assign fetch_ok      = 1'b1;
  assign pc_misaligned = 1'b0;
`endif

  assign inst_sram_en    = ~reset & fs_allowin & fetch_ok;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  // A redirect arriving while IF holds a valid instruction means that instruction is wrong-path.
  assign fs_to_ds_valid = ~reset & fs_valid_reg & ~br_taken;
  assign fs_to_ds_pc    = fs_pc_reg;
  assign fs_to_ds_inst  = pc_misaligned ? 32'h0 :
                          buf_valid_reg ? inst_buf_reg : inst_sram_rdata;
  assign fs_excp_adef   = ~reset & fs_valid_reg & pc_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_reg       <= 1'b0;
      fs_pc_reg          <= RESET_PC - 32'd4;
      buf_valid_reg      <= 1'b0;
      inst_buf_reg       <= 32'h0;
      br_pending_reg     <= 1'b0;
      br_pend_target_reg <= 32'h0;
    end else if (fs_allowin) begin
      fs_valid_reg   <= 1'b1;
      fs_pc_reg      <= nextpc;
      br_pending_reg <= 1'b0;
      buf_valid_reg  <= 1'b0;
    end else if (br_taken) begin
      // Cannot issue the target now; remember it and fetch it once IF frees up.
      fs_valid_reg       <= 1'b0;
      br_pending_reg     <= 1'b1;
      br_pend_target_reg <= br_target;
      buf_valid_reg      <= 1'b0;
    end else if (!buf_valid_reg) begin
      // SRAM data is only valid on the first stall cycle, so capture it then.
      inst_buf_reg  <= inst_sram_rdata;
      buf_valid_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: the reference model tracks which pc IF holds and
// expects the delivered instruction to equal the memory word at that pc.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_excp_adef;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_pc    (fs_to_ds_pc),
    .fs_to_ds_inst  (fs_to_ds_inst),
    .fs_excp_adef   (fs_excp_adef)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  // Instruction memory: 1-cycle read latency, garbage when not enabled.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state: the pc IF holds and a redirect waiting to be issued.
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;

  initial begin
    logic        allow, ok, mis, exp_en, exp_v;
    logic [31:0] npc;

    reset      = 1'b1;
    ds_allowin = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    m_valid    = 1'b0;
    m_pc       = RESET_PC - 32'd4;
    m_pend     = 1'b0;
    m_ptgt     = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_sram_en", inst_sram_en, 1'b0);
    chk("reset_to_ds_valid", fs_to_ds_valid, 1'b0);
    chk("reset_adef", fs_excp_adef, 1'b0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc < 4) begin
        reset      = 1'b0;
        ds_allowin = 1'b1;
        br_taken   = 1'b0;
      end else begin
        reset      = ($urandom_range(0, 99) == 0);
        ds_allowin = ($urandom_range(0, 9) < 7);
        br_taken   = ($urandom_range(0, 99) < 15);
      end
      br_target = RESET_PC | ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 9) == 0)
        br_target[1:0] = 2'($urandom_range(0, 3));
      #1;

      allow = ~m_valid | ds_allowin;
      npc   = br_taken ? br_target : (m_pend ? m_ptgt : m_pc + 32'd4);
`ifdef IF_ADEF_EN
      ok  = (npc[1:0] == 2'b00);
      mis = (m_pc[1:0] != 2'b00);
`else
      ok  = 1'b1;
      mis = 1'b0;
`endif
      exp_en = ~reset & allow & ok;
      exp_v  = ~reset & m_valid & ~br_taken;

      chk("sram_en", inst_sram_en, exp_en);
      chk("sram_we", inst_sram_we, 1'b0);
      if (!reset && allow)
        chk("sram_addr", inst_sram_addr, npc);
      chk("to_ds_valid", fs_to_ds_valid, exp_v);
      if (exp_v) begin
        chk("to_ds_pc", fs_to_ds_pc, m_pc);
        chk("to_ds_inst", fs_to_ds_inst, mis ? 32'h0 : mem_word(m_pc));
      end
      chk("excp_adef", fs_excp_adef, ~reset & m_valid & mis);

      if (exp_v && ds_allowin)
        $display("cycle %0d: deliver pc=%08h inst=%08h adef=%0d",
                 cyc, fs_to_ds_pc, fs_to_ds_inst, fs_excp_adef);

      if (reset) begin
        m_valid = 1'b0;
        m_pc    = RESET_PC - 32'd4;
        m_pend  = 1'b0;
      end else if (allow) begin
        m_valid = 1'b1;
        m_pc    = npc;
        m_pend  = 1'b0;
      end else if (br_taken) begin
        m_valid = 1'b0;
        m_pend  = 1'b1;
        m_ptgt  = br_target;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
